// File: rtl/multiciclo_core.sv
// Multi-cycle MIPS-subset core: one instruction per valid/ready handshake, walked through
// decode, execute, memory and write-back, with a register file and synchronous data memory.
module multiciclo_core #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NREG      = 32,
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              done,
    output logic              illegal,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int unsigned IW = $clog2(NREG);
    localparam int unsigned MW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {StIdle, StDecode, StExec, StMem, StWb} state_e;
    state_e state_q, state_d;

    logic [31:0]       instr_q;
    logic [DATA_W-1:0] a_q, b_q, imm_q, alu_q, mdr_q, result_q;
    logic              zero_q;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] mem_q  [MEM_DEPTH];

    logic [5:0]        op, funct;
    logic              is_r, is_addi, is_lw, is_sw, r_legal, legal, wr_en;
    logic [IW-1:0]     rs_idx, rt_idx, rd_idx, wr_idx;
    logic [MW-1:0]     mem_idx;
    logic [DATA_W-1:0] alu_b, alu_d, wb_data;
    logic              unused_bits;

    // The latched instruction stays stable until the next accept, so decode is recomputed from it.
    assign op      = instr_q[31:26];
    assign funct   = instr_q[5:0];
    assign rs_idx  = instr_q[21 +: IW];
    assign rt_idx  = instr_q[16 +: IW];
    assign rd_idx  = instr_q[11 +: IW];
    assign is_r    = (op == 6'h00);
    assign is_addi = (op == 6'h08);
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2B);
    assign legal   = (is_r & r_legal) | is_addi | is_lw | is_sw;
    assign mem_idx = alu_q[MW-1:0];
    assign alu_b   = is_r ? b_q : imm_q;
    assign wb_data = is_lw ? mdr_q : alu_q;
    assign wr_idx  = is_r ? rd_idx : rt_idx;
    assign wr_en   = (state_q == StWb) & legal & ~is_sw & (wr_idx != '0);

    assign unused_bits = ^{instr_q, dbg_addr, alu_q};

    always_comb begin
        r_legal = 1'b0;
        case (funct)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A: r_legal = 1'b1;
            default:                                  r_legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_d = a_q + alu_b;
        if (is_r) begin
            case (funct)
                6'h22:   alu_d = a_q - b_q;
                6'h24:   alu_d = a_q & b_q;
                6'h25:   alu_d = a_q | b_q;
                6'h27:   alu_d = ~(a_q | b_q);
                6'h2A:   alu_d = DATA_W'($signed(a_q) < $signed(b_q));
                default: alu_d = a_q + b_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (instr_valid) state_d = StDecode;
            StDecode: state_d = legal ? StExec : StWb;
            StExec:   state_d = (is_lw | is_sw) ? StMem : StWb;
            StMem:    state_d = StWb;
            StWb:     state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            if (state_q == StIdle && instr_valid) instr_q <= instr;
            if (state_q == StDecode) begin
                a_q   <= regs_q[rs_idx];
                b_q   <= regs_q[rt_idx];
                imm_q <= DATA_W'($signed(instr_q[15:0]));
            end
            if (state_q == StExec) alu_q <= alu_d;
            if (state_q == StMem && is_lw) mdr_q <= mem_q[mem_idx];
            // Illegal instructions retire without disturbing the visible result.
            if (state_q == StWb && legal) begin
                result_q <= wb_data;
                zero_q   <= (wb_data == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[wr_idx] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) mem_q[i] <= '0;
        end else if (state_q == StMem && is_sw) begin
            mem_q[mem_idx] <= b_q;
        end
    end

    assign instr_ready = (state_q == StIdle);
    assign done        = (state_q == StWb);
    assign illegal     = (state_q == StWb) & ~legal;
    assign result      = result_q;
    assign zero        = zero_q;
    assign dbg_data    = regs_q[dbg_addr[IW-1:0]];

endmodule

// File: tb/tb_multiciclo_core.sv
// Drives a default-width core and a 16-bit/8-register/16-word core with the same instruction
// stream, checking both against an instruction-level reference model.
module tb_multiciclo_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic [4:0]  dbg_addr = '0;

    logic        rdy0, rdy1, dn0, dn1, ill0, ill1, z0, z1;
    logic [31:0] res0, dbg0;
    logic [15:0] res1, dbg1;

    int checks = 0;
    int errors = 0;

    longint unsigned m_reg [2][32];
    longint unsigned m_mem [2][32];
    longint unsigned m_res [2];
    int W  [2] = '{32, 16};
    int NR [2] = '{32, 8};
    int MD [2] = '{32, 16};

    always #5 clk = ~clk;

    multiciclo_core u_dut0 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(rdy0), .done(dn0), .illegal(ill0), .result(res0), .zero(z0),
        .dbg_addr(dbg_addr), .dbg_data(dbg0)
    );

    multiciclo_core #(.DATA_W(16), .NREG(8), .MEM_DEPTH(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(rdy1), .done(dn1), .illegal(ill1), .result(res1), .zero(z1),
        .dbg_addr(dbg_addr), .dbg_data(dbg1)
    );

    function automatic longint unsigned o_res(input int k);
        return (k == 0) ? 64'(res0) : 64'(res1);
    endfunction

    function automatic longint unsigned o_dbg(input int k);
        return (k == 0) ? 64'(dbg0) : 64'(dbg1);
    endfunction

    function automatic logic o_zero(input int k);
        return (k == 0) ? z0 : z1;
    endfunction

    function automatic longint sx(input longint unsigned v, input int w);
        return v[w-1] ? longint'(v) - (longint'(1) << w) : longint'(v);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_res[k] = 0;
            for (int i = 0; i < 32; i++) begin
                m_reg[k][i] = 0;
                m_mem[k][i] = 0;
            end
        end
    endtask

    // Instruction-level semantics: returns expected latency and illegal flag, updates state.
    task automatic model_step(input int k, input logic [31:0] ins, output int lat, output bit ill);
        longint unsigned mk, a, b, imm, r, addr;
        int rs, rt, rd, wi;
        logic [5:0] op, fn;
        mk  = (64'd1 << W[k]) - 1;
        op  = ins[31:26];
        fn  = ins[5:0];
        rs  = int'(ins[25:21]) % NR[k];
        rt  = int'(ins[20:16]) % NR[k];
        rd  = int'(ins[15:11]) % NR[k];
        a   = m_reg[k][rs];
        b   = m_reg[k][rt];
        imm = {{48{ins[15]}}, ins[15:0]} & mk;
        ill = 1'b0;
        lat = 3;
        r   = 0;
        wi  = 0;
        if (op == 6'h00) begin
            wi = rd;
            case (fn)
                6'h20:   r = a + b;
                6'h22:   r = a - b;
                6'h24:   r = a & b;
                6'h25:   r = a | b;
                6'h27:   r = ~(a | b);
                6'h2A:   r = (sx(a, W[k]) < sx(b, W[k])) ? 1 : 0;
                default: ill = 1'b1;
            endcase
        end else if (op == 6'h08) begin
            r  = a + imm;
            wi = rt;
        end else if (op == 6'h23) begin
            addr = (a + imm) & mk;
            r    = m_mem[k][int'(addr % longint'(MD[k]))];
            wi   = rt;
            lat  = 4;
        end else if (op == 6'h2B) begin
            addr = (a + imm) & mk;
            m_mem[k][int'(addr % longint'(MD[k]))] = b;
            r    = addr;
            lat  = 4;
        end else begin
            ill = 1'b1;
        end
        if (ill) begin
            lat = 2;
        end else begin
            m_res[k] = r & mk;
            if (wi != 0) m_reg[k][wi] = r & mk;
        end
    endtask

    task automatic run(input logic [31:0] ins, input bit hold);
        int lat, exp_lat;
        bit got, exp_ill;
        int di;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL ready_idle ins=%h got %b%b want 11", ins, rdy0, rdy1);
        end
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (!hold) instr_valid = 1'b0;
            if (dn0 === 1'b1) begin
                got = 1'b1;
                lat = c;
                break;
            end
            checks++;
            if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
                errors++;
                $display("FAIL ready_busy ins=%h cyc=%0d got %b%b want 00", ins, c, rdy0, rdy1);
            end
        end
        model_step(0, ins, exp_lat, exp_ill);
        model_step(1, ins, exp_lat, exp_ill);
        checks++;
        if (!got || lat != exp_lat) begin
            errors++;
            $display("FAIL latency ins=%h got %0d (seen=%0b) want %0d", ins, lat, got, exp_lat);
        end
        checks++;
        if (dn1 !== 1'b1 || ill0 !== exp_ill || ill1 !== exp_ill) begin
            errors++;
            $display("FAIL done_illegal ins=%h got dn1=%b ill=%b%b want 1 %b", ins, dn1, ill0,
                     ill1, exp_ill);
        end
        dbg_addr = (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            di = int'(dbg_addr) % NR[k];
            checks++;
            if (o_res(k) !== m_res[k] || o_zero(k) !== (m_res[k] == 0)) begin
                errors++;
                $display("FAIL result core%0d ins=%h got %h z=%b want %h z=%b", k, ins, o_res(k),
                         o_zero(k), m_res[k], m_res[k] == 0);
            end
            checks++;
            if (o_dbg(k) !== m_reg[k][di]) begin
                errors++;
                $display("FAIL dbg core%0d ins=%h reg%0d got %h want %h", k, ins, di, o_dbg(k),
                         m_reg[k][di]);
            end
        end
        checks++;
        if (dn0 !== 1'b0 || dn1 !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse ins=%h got %b%b want 00", ins, dn0, dn1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        #12;
        checks++;
        if (dn0 !== 0 || dn1 !== 0 || ill0 !== 0 || ill1 !== 0 || res0 !== 0 || res1 !== 0 ||
            z0 !== 1 || z1 !== 1) begin
            errors++;
            $display("FAIL reset_outputs got dn=%b%b ill=%b%b res=%h/%h z=%b%b want 0 0 0 1",
                     dn0, dn1, ill0, ill1, res0, res1, z0, z1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dbg_addr = 5'd1;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1 || rdy1 !== 1 || dbg0 !== 0 || dbg1 !== 0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b%b dbg=%h/%h want 11 0", rdy0, rdy1, dbg0, dbg1);
        end
    endtask

    task automatic test_alu();
        run(32'h2001_0005, 1'b0);            // addi r1,r0,5
        checks++;
        if (res0 !== 32'd5 || z0 !== 1'b0 || dbg0 !== 32'd5) begin
            errors++;
            $display("FAIL addi5 got res=%h z=%b dbg=%h want 5 0 5", res0, z0, dbg0);
        end
        run(32'h2002_FFF9, 1'b0);            // addi r2,r0,-7
        run(32'h0022_1820, 1'b0);            // add r3,r1,r2
        checks++;
        if (res0 !== 32'hFFFF_FFFE || res1 !== 16'hFFFE) begin
            errors++;
            $display("FAIL add_neg got %h/%h want fffffffe/fffe", res0, res1);
        end
        run(32'h0041_202A, 1'b0);            // slt r4,r2,r1
        checks++;
        if (dbg0 !== 32'd1 || dbg1 !== 16'd1) begin
            errors++;
            $display("FAIL slt got %h/%h want 1/1", dbg0, dbg1);
        end
        run(32'h0021_2822, 1'b0);            // sub r5,r1,r1
        checks++;
        if (res0 !== 32'd0 || z0 !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero got res=%h z=%b want 0 1", res0, z0);
        end
        run(32'h0022_3824, 1'b0);            // and r7,r1,r2
        run(32'h0022_3825, 1'b0);            // or
        run(32'h0022_3827, 1'b0);            // nor
    endtask

    task automatic test_mem();
        run(32'hAC01_0003, 1'b0);            // sw r1,3(r0)
        run(32'h8C06_0003, 1'b0);            // lw r6,3(r0)
        checks++;
        if (res0 !== 32'd5 || dbg0 !== 32'd5) begin
            errors++;
            $display("FAIL lw3 got res=%h dbg=%h want 5 5", res0, dbg0);
        end
        run(32'h8C08_0023, 1'b0);            // lw r8,35(r0) wraps to word 3
        checks++;
        if (res0 !== 32'd5 || res1 !== 16'd5) begin
            errors++;
            $display("FAIL lw_wrap got %h/%h want 5/5", res0, res1);
        end
        run(32'h8C08_0013, 1'b0);            // lw r8,19(r0): word 3 only in the 16-deep memory
    endtask

    task automatic test_x0_illegal();
        run(32'h2000_0009, 1'b0);            // addi r0,r0,9
        checks++;
        if (res0 !== 32'd9 || dbg0 !== 32'd0) begin
            errors++;
            $display("FAIL x0_write got res=%h dbg0=%h want 9 0", res0, dbg0);
        end
        run(32'hFC22_1800, 1'b0);            // op 0x3F
        run(32'h0022_1801, 1'b0);            // R-type funct 0x01
        checks++;
        if (res0 !== 32'd9 || z0 !== 1'b0) begin
            errors++;
            $display("FAIL illegal_hold got res=%h z=%b want 9 0", res0, z0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) run(32'h2129_0001, 1'b1);   // addi r9,r9,1
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if (dbg0 !== 32'd3) begin
            errors++;
            $display("FAIL b2b_count got %h want 3", dbg0);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (dn0 !== 1'b0 || rdy0 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_quiet cyc=%0d got dn=%b rdy=%b want 0 1", i, dn0, rdy0);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run(32'h2001_0055, 1'b0);            // addi r1,r0,0x55
        @(negedge clk);
        instr = 32'hAC01_0003;               // sw r1,3(r0)
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;                        // cycle 3 = MEM
        model_clear();
        #1;
        checks++;
        if (rdy0 !== 1 || dn0 !== 0 || res0 !== 0 || z0 !== 1 || rdy1 !== 1 || res1 !== 0) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b%b dn=%b res=%h/%h z=%b want 11 0 0 1", rdy0,
                     rdy1, dn0, res0, res1, z0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(32'h8C06_0003, 1'b0);            // lw r6,3(r0)
        checks++;
        if (res0 !== 32'd0 || res1 !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_mem got %h/%h want 0/0", res0, res1);
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [5:0]  fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        logic [5:0]  op;
        for (int i = 0; i < 60; i++) begin
            ins = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2: ins = {6'h00, ins[25:6], fns[$urandom_range(0, 5)]};
                3, 4:    ins = {6'h08, ins[25:0]};
                5:       ins = {6'h23, ins[25:16], 10'd0, ins[5:0]};
                6:       ins = {6'h2B, ins[25:16], 10'd0, ins[5:0]};
                7:       ins = {6'h23, ins[25:0]};
                8: begin
                    op = 6'($urandom_range(1, 63));
                    if (op == 6'h08 || op == 6'h23 || op == 6'h2B) op = 6'h3E;
                    ins = {op, ins[25:0]};
                end
                default: ins = {6'h00, ins[25:6], 6'h03};
            endcase
            run(ins, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_x0_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multiciclo_core.md
Name: multiciclo_core

Overview:
- Parametrised multi-cycle successor to the single-cycle R/I-type datapath.
- Accepts one 32-bit MIPS-format instruction over a valid/ready handshake.
- Executes it through a registered FSM (decode, execute, memory, write-back) and pulses done with the result.
- Adds a register file with x0 hardwired to zero, synchronous data memory, illegal-op detection, configurable data width and depths, and a debug register read port.

Parameters:
- DATA_W, 32, datapath/register/memory word width; must be >= 16.
- NREG, 32, number of registers; power of two, <= 32; register index uses the low clog2(NREG) bits of rs/rt/rd.
- MEM_DEPTH, 32, data memory words; power of two; word index = alu_result[clog2(MEM_DEPTH)-1:0].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct, [15:0] imm
- instr_valid  in  1  instr present
- instr_ready  out  1  core is IDLE and can accept
- done  out  1  one-cycle pulse: instruction retired
- illegal  out  1  valid with done: instruction was not executed
- result  out  DATA_W  ALU result (R/addi/sw) or loaded word (lw), held until next done
- zero  out  1  result == 0, held with result
- dbg_addr  in  5  debug register index
- dbg_data  out  DATA_W  combinational read of reg[dbg_addr]; 0 for index 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all registers and memory words = 0; result=0, zero=1, done=0, illegal=0; instr_ready=1 once rst_n is released.
- Handshake: the instruction is latched on a rising edge where instr_valid & instr_ready. instr_ready=1 only in IDLE; instr is ignored otherwise.
- FSM states:
  - IDLE: on accept, latch instr and go to DECODE.
  - DECODE: read rs/rt into registers A/B; sign-extend imm to DATA_W into IMM; classify.
    - Illegal op/funct → WB with the illegal flag set.
    - Otherwise → EXEC.
  - EXEC: ALU_OUT = A op (B or IMM).
    - R-type/addi → WB.
    - lw/sw → MEM.
  - MEM:
    - lw: MDR = mem[idx].
    - sw: mem[idx] = B at end of cycle.
    - Then → WB.
  - WB:
    - done=1 this cycle; illegal=flag.
    - result/zero updated at end of cycle.
    - Register write at end of cycle: R-type → rd; addi/lw → rt.
    - Writes to index 0 are discarded.
    - Then → IDLE.
- Latency, counting the accept edge as edge 0:
  - R/addi: done high in cycle 3.
  - lw/sw: done high in cycle 4.
  - illegal: done high in cycle 2.
  - Back-to-back: next accept possible in the cycle after WB. Throughput is 1 instruction per 4 or 5 cycles.
- Encodings:
  - op 0x00 R-type, funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt.
  - op 0x08 addi, 0x23 lw, 0x2B sw.
  - Anything else is illegal.
- Arithmetic:
  - add/sub/addi and address computation wrap modulo 2^DATA_W; no overflow trap.
  - slt is a signed compare giving 1 or 0.
  - Memory index uses the low index bits only, so out-of-range addresses wrap.
- Illegal: no register write, no memory write; result and zero are left unchanged.
- sw: result = computed address; no register write.
- lw: result = loaded word.
- Reset mid-instruction: immediate return to IDLE. No partial write completes after rst_n falls. Register file and memory are cleared.
- dbg_data is combinational and reflects a WB write from the following cycle onward.

Test Plan:
- Reset then addi r1,r0,5 (0x20010005) → done in cycle 3, result=5, zero=0, dbg reg1=5.
- With r1=5: addi r2,r0,-7 then add r3,r1,r2 (0x00221820) → result=0xFFFFFFFE; then slt r4,r2,r1 → r4=1; sub r5,r1,r1 → result=0, zero=1.
- sw r1,3(r0) (0xAC010003) then lw r6,3(r0) (0x8C060003) → done in cycle 4 for each, result=5, reg6=5; lw from address 35 with MEM_DEPTH=32 → word 3 read.
- addi r0,r0,9 → done, result=9, dbg reg0 still 0; op 0x3F or R-type funct 0x01 → done in cycle 2, illegal=1, no state change.
- Hold instr_valid high across a sequence → exactly one accept per IDLE visit; instr_ready=0 during DECODE..WB.
- Assert rst_n=0 during MEM of an sw → memory word stays 0; after release instr_ready=1 and result=0.
- Rerun addi/add/sw/lw with DATA_W=16, NREG=8, MEM_DEPTH=16 → wrap at 16 bits, register index = low 3 bits.
